// File: rtl/burst_arb_pkg.sv
// burst_arb_pkg: shared state encoding and default watchdog limit for the burst arbiter
package burst_arb_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } state_t;
  localparam int TMO_DEF = 200;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after i_ptr with wrap
// Ports: i_req  request vector
//        i_ptr  index where the search starts
//        o_gnt  one-hot winner (zero when no request)
//        o_idx  index of the winner
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);
  logic [IW:0] w_s;
  // Walk offsets from farthest to nearest so the nearest set bit is written last and wins.
  always_comb begin
    w_s   = '0;
    o_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_s = {1'b0, i_ptr} + (IW + 1)'(k);
      w_s = (w_s >= (IW + 1)'(NREQ)) ? w_s - (IW + 1)'(NREQ) : w_s;
      o_idx = i_req[w_s[IW-1:0]] ? w_s[IW-1:0] : o_idx;
    end
    o_gnt = |i_req ? NREQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/burst_arb.sv
// burst_arb: round-robin arbiter sequencing one burst-write engine over a four-phase req/ack handshake
// Ports: clk      system clock
//        rst      synchronous reset, active low
//        req      per-requester level request, held until its done pulse
//        eng_ack  engine ready level (already synchronous)
//        eng_req  request level to the engine
//        gnt      one-hot grant, held until release completes
//        done     one-cycle pulse on the granted bit at burst completion
//        tmo_err  one-cycle pulse when the watchdog aborts
//        busy     high while the sequencer is not idle
module burst_arb
  import burst_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int TMO_W = 8,
  parameter int TMO   = TMO_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            eng_ack,
  output logic            eng_req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            tmo_err,
  output logic            busy
);
  localparam int IW = $clog2(NREQ);
  state_t          r_state, w_next;
  logic [NREQ-1:0] r_gnt, r_done, w_gnt, w_done, w_pick_gnt;
  logic [IW-1:0]   r_ptr, r_idx, w_ptr, w_idx, w_pick_idx;
  logic [TMO_W-1:0] r_wd, w_wd;
  logic            r_eng_req, r_tmo, r_busy, w_eng_req, w_abort, w_fin, w_end;

  assign eng_req = r_eng_req;
  assign gnt     = r_gnt;
  assign done    = r_done;
  assign tmo_err = r_tmo;
  assign busy    = r_busy;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_wd      <= '0;
      r_eng_req <= 1'b0;
      r_tmo     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_ptr     <= w_ptr;
      r_idx     <= w_idx;
      r_wd      <= w_wd;
      r_eng_req <= w_eng_req;
      r_tmo     <= w_abort;
      r_busy    <= w_next != IDLE;
    end
  end

  // Watchdog abort overrides any handshake progress in the same cycle.
  always_comb begin
    w_abort = (r_state == WAIT_ACK || r_state == RELEASE) && r_wd == TMO_W'(TMO - 1);
    w_next  = r_state;
    case (r_state)
      IDLE:     w_next = |req ? GRANT : IDLE;
      GRANT:    w_next = WAIT_ACK;
      WAIT_ACK: w_next = eng_ack ? RELEASE : WAIT_ACK;
      RELEASE:  w_next = eng_ack ? RELEASE : IDLE;
      default:  w_next = IDLE;
    endcase
    w_next = w_abort ? IDLE : w_next;
  end

  always_comb begin
    w_fin     = r_state == RELEASE && !eng_ack && !w_abort;
    w_end     = w_fin || w_abort;
    w_gnt     = (r_state == IDLE) ? w_pick_gnt : w_end ? '0 : r_gnt;
    w_idx     = (r_state == IDLE) ? w_pick_idx : r_idx;
    w_eng_req = w_next == WAIT_ACK;
    w_done    = w_fin ? r_gnt : '0;
    w_ptr     = w_end ? ((r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1) : r_ptr;
    // Counter restarts on every state change and saturates instead of wrapping.
    w_wd      = (w_next != r_state) ? '0 :
                ((r_state == WAIT_ACK || r_state == RELEASE) && r_wd != '1) ? r_wd + 1'b1 : r_wd;
  end
endmodule

// File: tb/tb_burst_arb.sv
// tb_burst_arb: directed self-checking bench for burst_arb
module tb_burst_arb;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       eng_ack;
  logic       eng_req;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       tmo_err;
  logic       busy;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  burst_arb dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .eng_ack (eng_ack),
    .eng_req (eng_req),
    .gnt     (gnt),
    .done    (done),
    .tmo_err (tmo_err),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Serve one transaction with a simple engine model; nreq is driven in the done cycle.
  task automatic burst(input int ack_dly, input int drop_dly, input logic [3:0] exp,
                       input logic [3:0] nreq, input string tag);
    int n;
    n = 0;
    while (gnt == 4'b0 && n < 8) begin tick(); n++; end
    check({tag, "_gnt"}, 32'(gnt), 32'(exp));
    n = 0;
    while (!eng_req && n < 8) begin tick(); n++; end
    check({tag, "_req_up"}, 32'(eng_req), 32'd1);
    repeat (ack_dly) tick();
    eng_ack = 1'b1;
    tick();
    check({tag, "_req_down"}, 32'(eng_req), 32'd0);
    check({tag, "_gnt_hold"}, 32'(gnt), 32'(exp));
    repeat (drop_dly - 1) tick();
    check({tag, "_no_early_done"}, 32'(done), 32'd0);
    eng_ack = 1'b0;
    tick();
    check({tag, "_done"}, 32'(done), 32'(exp));
    check({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
    req = nreq;
    tick();
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_next_gnt"}, 32'(|gnt), 32'(|nreq));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic tmo_early;
    rst = 1'b0;
    req = 4'b1111;
    eng_ack = 1'b0;
    repeat (3) tick();
    check("rst_eng_req", 32'(eng_req), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'b0001);
    check("post_rst_req_low", 32'(eng_req), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd1);
    tick();
    check("post_rst_req_high", 32'(eng_req), 32'd1);
    req = 4'b0000;
    burst(4, 2, 4'b0001, 4'b0100, "drop_req");
    burst(25, 3, 4'b0100, 4'b0011, "single");
    burst(3, 2, 4'b0001, 4'b0011, "wrap0");
    burst(3, 2, 4'b0010, 4'b1011, "wrap1");
    burst(3, 2, 4'b1000, 4'b1111, "ptr2_1011");
    for (int t = 0; t < 8; t++)
      burst(3, 2, 4'(1 << (t % 4)), (t == 7) ? 4'b0011 : 4'b1111, $sformatf("rr%0d", t));
    for (int n = 0; n < 8 && !eng_req; n++) tick();
    check("tmo_req_up", 32'(eng_req), 32'd1);
    check("tmo_gnt", 32'(gnt), 32'b0001);
    tmo_early = 1'b0;
    repeat (199) begin
      tick();
      tmo_early |= tmo_err | (|done) | !eng_req;
    end
    check("tmo_not_early", 32'(tmo_early), 32'd0);
    tick();
    check("tmo_pulse", 32'(tmo_err), 32'd1);
    check("tmo_eng_req", 32'(eng_req), 32'd0);
    check("tmo_gnt_clr", 32'(gnt), 32'd0);
    check("tmo_no_done", 32'(done), 32'd0);
    req = 4'b0010;
    tick();
    check("tmo_pulse_1cyc", 32'(tmo_err), 32'd0);
    check("tmo_next_gnt", 32'(gnt), 32'b0010);
    burst(3, 2, 4'b0010, 4'b0100, "after_tmo");
    for (int n = 0; n < 8 && !eng_req; n++) tick();
    tick();
    check("midrst_in_wait", 32'(eng_req), 32'd1);
    rst = 1'b0;
    tick();
    check("midrst_eng_req", 32'(eng_req), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_tmo", 32'(tmo_err), 32'd0);
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check("midrst_ptr0", 32'(gnt), 32'b0001);
    req = 4'b0000;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/burst_arb.md
Name: burst_arb

Overview:
Round-robin arbiter and sequencer that shares one burst-write engine between NREQ requesters. The engine is the req-driven CS0/DATA/CS1/REDY chip-select/write-enable/address generator. The arbiter grants one requester at a time and drives the engine's req input with a four-phase handshake. It returns a per-requester done pulse and guards each phase with a watchdog timeout.

Parameters:
NREQ, 4, number of requesters (2..8)
TMO_W, 8, width of watchdog counter
TMO, 200, max cycles allowed in any handshake phase before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0)
req  in  NREQ  per-requester burst request, level, held until its done pulse
eng_ack  in  1  engine ready level, high while engine is in REDY
eng_req  out  1  request to engine, level
gnt  out  NREQ  one-hot grant, held from grant to release complete
done  out  NREQ  one-cycle pulse on the granted bit when its burst finishes
tmo_err  out  1  one-cycle pulse when the watchdog aborts a transaction
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, eng_req=0, gnt=0, done=0, tmo_err=0, busy=0, rr pointer=0, watchdog=0. Reset mid-transaction drops eng_req the next cycle; no done pulse is issued.
- All outputs are registered. eng_ack is treated as already synchronous; it gets no extra synchronizer.
- States: IDLE, GRANT, WAIT_ACK, RELEASE.
- IDLE: if any req bit is 1, pick the first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...). Load gnt one-hot. Go to GRANT.
- GRANT: one cycle. Set eng_req=1 and go to WAIT_ACK. This gives 1 cycle from gnt rising to eng_req rising.
- WAIT_ACK: hold eng_req=1. On eng_ack==1, set eng_req=0 and go to RELEASE.
- RELEASE: wait for eng_ack==0. Then pulse done[granted]=1, clear gnt, set ptr=(granted index+1) mod NREQ, and go to IDLE.
- done and gnt clear are in the same cycle. The next grant can start no earlier than the following cycle, so there is at least one IDLE cycle between transactions.
- Fairness: a requester that holds req is granted within NREQ transactions.
- A req bit that drops while granted does not abort the transaction. The transaction completes normally and done still pulses.
- Simultaneous requests in IDLE: the lowest index at or after ptr wins. Example: ptr=2, req=4'b1011 grants bit 3.
- Watchdog: cleared on every state change and incremented every cycle while in WAIT_ACK or RELEASE.
- When the watchdog reaches TMO-1 it aborts: pulse tmo_err=1, set eng_req=0, clear gnt, advance ptr past the granted index, go to IDLE, and issue no done pulse.
- Counter width: TMO must fit in TMO_W bits. The counter saturates and does not wrap.
- An eng_ack already high when entering WAIT_ACK (stale) is accepted as the ack. RELEASE then guarantees the engine returns to idle.
- busy is the registered copy of (state!=IDLE).

Decomposition:
- Shared package burst_arb_pkg: state encoding constants (IDLE=2'd0, GRANT=2'd1, WAIT_ACK=2'd2, RELEASE=2'd3) and the default TMO value.
- One natural sub-module, rr_pick: combinational round-robin priority picker. Inputs are req and ptr; outputs are the one-hot grant and its index. It is reused by later multi-engine schedulers.
- FSM, watchdog and output registers stay in burst_arb.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=4'b1111. Required: eng_req=0, gnt=0, busy=0. After release, gnt=4'b0001 on the first cycle, then eng_req=1 one cycle later.
- Single burst: req=4'b0100, engine model raises eng_ack 25 cycles after eng_req and drops it 3 cycles after eng_req falls. Required: gnt=4'b0100 throughout, eng_req falls the cycle after eng_ack rises, done=4'b0100 for exactly one cycle after eng_ack falls, ptr becomes 3.
- Round-robin: hold req=4'b1111 for 8 transactions. Required grant order: 0,1,2,3,0,1,2,3. One IDLE cycle between each done and the next gnt.
- Wrap priority: ptr=3, then req=4'b0011 arrives. Required: gnt=4'b0001 next, then 4'b0010.
- Timeout: TMO=200, engine never asserts eng_ack. Required: tmo_err pulses once at 200 cycles after entering WAIT_ACK, eng_req=0, gnt=0, no done pulse, next requester granted.
- Mid-op reset: assert rst=0 during WAIT_ACK. Required: the next cycle has eng_req=0, gnt=0, state IDLE, ptr=0, and no done or tmo_err pulse.
